// File: rtl/coin_feeder_if.sv
// rtl/coin_feeder_if.sv - wallet/purchase/vending-machine link of coin_feeder.
// master drives wallet, purchase and machine indications; slave is the feeder.
interface coin_feeder_if;
   logic       load;
   logic [3:0] load_nickles;
   logic [3:0] load_dimes;
   logic       start;
   logic       product;
   logic       change;
   logic       nickle;
   logic       dime;
   logic       busy;
   logic       done;
   logic       vended;
   logic       fault;
   logic [3:0] nickles_left;
   logic [3:0] dimes_left;
   logic [7:0] change_total;

   modport master (
      output load, load_nickles, load_dimes, start, product, change,
      input  nickle, dime, busy, done, vended, fault,
             nickles_left, dimes_left, change_total
   );

   modport slave (
      input  load, load_nickles, load_dimes, start, product, change,
      output nickle, dime, busy, done, vended, fault,
             nickles_left, dimes_left, change_total
   );
endinterface

// File: rtl/coin_feeder.sv
// rtl/coin_feeder.sv - pays an item price from a nickel/dime wallet, one coin pulse at a time.
// Optional WAIT timeout enabled by defining COIN_FEEDER_TIMEOUT_EN.
module coin_feeder #(
   parameter int PRICE_N  = 3,
   parameter int COIN_GAP = 1,
   parameter int TIMEOUT  = 8
) (
   input logic          clk,
   input logic          reset,
   coin_feeder_if.slave bus
);

   if (PRICE_N < 1 || PRICE_N > 7 || COIN_GAP < 0 || COIN_GAP > 15 ||
       TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("coin_feeder: parameter out of legal range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_COIN,
      S_GAP,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [2:0] PRICE    = 3'(PRICE_N);
   localparam logic [5:0] PRICE_W  = 6'(PRICE_N);
   localparam logic [3:0] GAP_LOAD = 4'((COIN_GAP > 0) ? COIN_GAP - 1 : 0);

   state_t     state_q, state_d;
   logic [2:0] owed_q, owed_d;
   logic [3:0] nickles_q, nickles_d;
   logic [3:0] dimes_q, dimes_d;
   logic       nickle_q, nickle_d;
   logic       dime_q, dime_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       vended_q, vended_d;
   logic       fault_q, fault_d;
   logic [7:0] change_total_q, change_total_d;
   logic [3:0] gap_q, gap_d;
   logic       first_q, first_d;
   logic [5:0] funds;

`ifdef COIN_FEEDER_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

   // Wallet value in nickels: a dime counts as two.
   assign funds = {1'b0, dimes_q, 1'b0} + {2'b00, nickles_q};

   always_comb begin
      state_d        = state_q;
      owed_d         = owed_q;
      nickles_d      = nickles_q;
      dimes_d        = dimes_q;
      nickle_d       = 1'b0;
      dime_d         = 1'b0;
      done_d         = 1'b0;
      vended_d       = vended_q;
      fault_d        = fault_q;
      change_total_d = change_total_q;
      gap_d          = gap_q;
      first_d        = first_q;
`ifdef COIN_FEEDER_TIMEOUT_EN
      wait_cnt_d     = wait_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.load) begin
               nickles_d = bus.load_nickles;
               dimes_d   = bus.load_dimes;
            end else if (bus.start) begin
               owed_d   = PRICE;
               vended_d = 1'b0;
               fault_d  = 1'b0;
               first_d  = 1'b1;
               state_d  = S_CHECK;
            end
         end

         S_CHECK: begin
            first_d = 1'b0;
            if (first_q && (funds < PRICE_W)) begin
               fault_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (owed_q == 3'd0) begin
`ifdef COIN_FEEDER_TIMEOUT_EN
               wait_cnt_d = 8'd0;
`endif
               state_d = S_WAIT;
            end else if ((owed_q >= 3'd2) && (dimes_q != 4'd0)) begin
               dime_d  = 1'b1;
               dimes_d = dimes_q - 4'd1;
               owed_d  = owed_q - 3'd2;
               state_d = S_COIN;
            end else if (nickles_q != 4'd0) begin
               nickle_d  = 1'b1;
               nickles_d = nickles_q - 4'd1;
               owed_d    = owed_q - 3'd1;
               state_d   = S_COIN;
            end else begin
               // Only a dime is left for the last nickel owed: overpay.
               dime_d  = 1'b1;
               dimes_d = (dimes_q != 4'd0) ? dimes_q - 4'd1 : 4'd0;
               owed_d  = (owed_q >= 3'd2) ? owed_q - 3'd2 : 3'd0;
               state_d = S_COIN;
            end
         end

         S_COIN: begin
            if (COIN_GAP == 0) begin
               state_d = S_CHECK;
            end else begin
               gap_d   = GAP_LOAD;
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            if (gap_q == 4'd0) begin
               state_d = S_CHECK;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end

         S_WAIT: begin
            if (bus.change) begin
               if (change_total_q != 8'hFF) change_total_d = change_total_q + 8'd1;
               if (nickles_q != 4'hF) nickles_d = nickles_q + 4'd1;
            end
            if (bus.product) begin
               vended_d = 1'b1;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end
`ifdef COIN_FEEDER_TIMEOUT_EN
            else if (wait_cnt_q == WAIT_LAST) begin
               fault_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
`endif
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         owed_q         <= 3'd0;
         nickles_q      <= 4'd0;
         dimes_q        <= 4'd0;
         nickle_q       <= 1'b0;
         dime_q         <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         vended_q       <= 1'b0;
         fault_q        <= 1'b0;
         change_total_q <= 8'd0;
         gap_q          <= 4'd0;
         first_q        <= 1'b0;
`ifdef COIN_FEEDER_TIMEOUT_EN
         wait_cnt_q     <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         owed_q         <= owed_d;
         nickles_q      <= nickles_d;
         dimes_q        <= dimes_d;
         nickle_q       <= nickle_d;
         dime_q         <= dime_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         vended_q       <= vended_d;
         fault_q        <= fault_d;
         change_total_q <= change_total_d;
         gap_q          <= gap_d;
         first_q        <= first_d;
`ifdef COIN_FEEDER_TIMEOUT_EN
         wait_cnt_q     <= wait_cnt_d;
`endif
      end
   end

   assign bus.nickle       = nickle_q;
   assign bus.dime         = dime_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.vended       = vended_q;
   assign bus.fault        = fault_q;
   assign bus.nickles_left = nickles_q;
   assign bus.dimes_left   = dimes_q;
   assign bus.change_total = change_total_q;

endmodule

// File: doc/coin_feeder.md
COIN_FEEDER -- requirements
Module: coin_feeder

Interface
REQ-001 SHALL have parameter PRICE_N, default 3: item price in nickels, legal range 1..7.
REQ-002 SHALL have parameter COIN_GAP, default 1: idle cycles between coin pulses, legal range 0..15.
REQ-003 SHALL have parameter TIMEOUT, default 8: WAIT-state cycle limit, legal range 1..255.
REQ-004 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  in  1  wallet load strobe, honoured only in IDLE.
REQ-007 SHALL have ports load_nickles and load_dimes  in  4 each  wallet contents captured on load.
REQ-008 SHALL have port start  in  1  purchase request pulse, honoured only in IDLE.
REQ-009 SHALL have ports product and change  in  1 each  dispense and nickel-return indications from the vending machine.
REQ-010 SHALL have ports nickle and dime  out  1 each  registered single-cycle coin pulses to the vending machine.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port done  out  1  single-cycle completion pulse.
REQ-013 SHALL have ports vended and fault  out  1 each  purchase result, valid from done until the next accepted start.
REQ-014 SHALL have ports nickles_left and dimes_left  out  4 each  current wallet counts.
REQ-015 SHALL have port change_total  out  8  count of change pulses received since reset, saturating at 255.

Function
REQ-016 SHALL implement the states IDLE, CHECK, COIN, GAP, WAIT and DONE.
REQ-017 In IDLE, load SHALL copy load_nickles and load_dimes into the wallet; when load and start are high together, load wins and start is ignored.
REQ-018 On start in IDLE, the block SHALL set owed to PRICE_N, clear vended and fault, and go to CHECK.
REQ-019 Funds check in the first CHECK: if 2*dimes_left + nickles_left < PRICE_N, the block SHALL go to DONE with fault=1, issue no coins, and leave the wallet unchanged.
REQ-020 In CHECK, coin selection SHALL be: owed==0 -> WAIT; otherwise if owed>=2 and dimes_left>0, a dime; otherwise if nickles_left>0, a nickel; otherwise a dime (overpay).
REQ-021 When a coin is chosen, the block SHALL decrement that wallet count, subtract 1 or 2 from owed (saturating at 0), and go to COIN.
REQ-022 In COIN, exactly one of nickle or dime SHALL be high for exactly one cycle; the first pulse appears in the second cycle after start is sampled.
REQ-023 From COIN, the block SHALL go to GAP for COIN_GAP cycles, or straight to CHECK when COIN_GAP=0; GAP then returns to CHECK.
REQ-024 In WAIT, product=1 SHALL cause a transition to DONE with vended=1.
REQ-025 In WAIT, each cycle with change=1 SHALL increment change_total and nickles_left, each saturating.
REQ-026 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-027 start while busy SHALL be ignored; product and change outside WAIT SHALL be ignored.

Reset
REQ-028 On reset, all outputs, counters and the wallet SHALL clear to 0 and the state SHALL return to IDLE by the next edge, including mid-purchase.
REQ-029 A coin pulse in flight when reset is asserted SHALL be deasserted at that same edge.

Configuration
REQ-030 With COIN_FEEDER_TIMEOUT_EN defined, WAIT SHALL count cycles and go to DONE with fault=1, vended=0 when TIMEOUT cycles elapse without product.
REQ-031 Without COIN_FEEDER_TIMEOUT_EN, WAIT SHALL wait indefinitely for product, and the TIMEOUT parameter SHALL have no effect.

Verification
REQ-032 Wallet N=3, D=0, start, machine model dispenses: expect 3 nickle pulses and no dime, then done, vended=1, nickles_left=0.
REQ-033 Wallet N=0, D=2, start, model returns product plus change: expect 2 dime pulses, then vended=1, change_total=1, nickles_left=1, dimes_left=0.
REQ-034 Wallet N=1, D=1, start: expect a dime then a nickel, then vended=1, change_total unchanged, wallet 0/0.
REQ-035 Wallet N=2, D=0, start: expect done with fault=1, no coin pulses, and wallet still 2/0.
REQ-036 With COIN_FEEDER_TIMEOUT_EN defined, TIMEOUT=8, N=3, product never asserted: expect done with fault=1 exactly 8 cycles after entering WAIT.
REQ-037 Assert reset during GAP after the first coin: expect busy=0, coin outputs 0 and wallet 0 after the next edge, and a subsequent start with an empty wallet to produce fault=1.
